lmsm_sequencer: RTL and testbench

//   Multi-cycle controller for IITB-RISC LM/SM (load/store multiple) instructions.

---
 rtl/lmsm_sequencer_if.sv | 43 ++++
 rtl/lmsm_sequencer.sv | 135 +++++++++++++
 tb/tb_lmsm_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// Issue and memory-side signals of the LM/SM sequencer.
// With LMSM_FLUSH_EN defined the interface also carries the flush abort request.
interface lmsm_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int MASK_WIDTH = 8
);
  localparam int IDX_WIDTH = $clog2(MASK_WIDTH);

  logic                  start;
  logic                  is_store;
  logic [MASK_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  mem_rdy;
`ifdef LMSM_FLUSH_EN
  logic                  flush;
`endif
  logic                  busy;
  logic                  addr_sel;
  logic [IDX_WIDTH-1:0]  reg_idx;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_en;
  logic                  mem_we;
  logic                  rf_we;
  logic                  done;

  // Issuer / memory side.
  modport master (
    output start, is_store, mask, base_addr, mem_rdy,
`ifdef LMSM_FLUSH_EN
    output flush,
`endif
    input  busy, addr_sel, reg_idx, mem_addr, mem_en, mem_we, rf_we, done
  );

  // Sequencer side.
  modport slave (
    input  start, is_store, mask, base_addr, mem_rdy,
`ifdef LMSM_FLUSH_EN
    input  flush,
`endif
    output busy, addr_sel, reg_idx, mem_addr, mem_en, mem_we, rf_we, done
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM multi-cycle sequencer for IITB-RISC.
// Walks the register mask lowest bit first, one memory transfer per accepted
// mem_rdy, and stalls the pipeline (busy) until the sequence completes.
// Optional feature: define LMSM_FLUSH_EN to enable the flush abort input.
module lmsm_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int MASK_WIDTH = 8,
  parameter int ADDR_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  lmsm_sequencer_if.slave    bus
);
  localparam int IDX_WIDTH = $clog2(MASK_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [MASK_WIDTH-1:0] pending_reg, pending_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  store_reg, store_next;

  // Lowest pending bit as a one-hot vector (two's-complement isolate).
  logic [MASK_WIDTH-1:0] lowest_bit;
  assign lowest_bit = pending_reg & (~pending_reg + MASK_WIDTH'(1));

  // Nothing beyond the lowest bit remains: this transfer is the last one.
  logic last_xfer;
  assign last_xfer = (pending_reg & ~lowest_bit) == '0;

  // One-hot to binary: index bit gi is the OR of one-hot positions whose index has bit gi set.
  logic [IDX_WIDTH-1:0][MASK_WIDTH-1:0] idx_sel;
  logic [IDX_WIDTH-1:0]                 idx_enc;
  genvar gi, gj;
  generate
    for (gi = 0; gi < IDX_WIDTH; gi++) begin : g_enc
      for (gj = 0; gj < MASK_WIDTH; gj++) begin : g_sel
        if (((gj >> gi) & 1) != 0) begin : g_on
          assign idx_sel[gi][gj] = lowest_bit[gj];
        end else begin : g_off
          assign idx_sel[gi][gj] = 1'b0;
        end
      end
      assign idx_enc[gi] = |idx_sel[gi];
    end
  endgenerate

  // A start is accepted only when no abort is requested in the same cycle.
  logic start_ok;
  logic abort;
`ifdef LMSM_FLUSH_EN
  assign start_ok = bus.start & ~bus.flush;
  assign abort    = bus.flush;
`else
  assign start_ok = bus.start;
  assign abort    = 1'b0;
`endif

  // State, pending mask, address and direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      addr_reg    <= '0;
      store_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      addr_reg    <= addr_next;
      store_reg   <= store_next;
    end
  end

  // Next-state logic and outputs decoded from the registered state.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    addr_next    = addr_reg;
    store_next   = store_reg;
    bus.busy     = 1'b0;
    bus.addr_sel = 1'b0;
    bus.reg_idx  = '0;
    bus.mem_addr = '0;
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.done     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          pending_next = bus.mask;
          addr_next    = bus.base_addr;
          store_next   = bus.is_store;
          state_next   = (bus.mask != '0) ? XFER : DONE;
        end
      end
      XFER: begin
        bus.busy     = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_en   = 1'b1;
        bus.reg_idx  = idx_enc;
        bus.mem_addr = addr_reg;
        bus.mem_we   = store_reg;
        bus.rf_we    = ~store_reg & bus.mem_rdy;
        if (bus.mem_rdy) begin
          pending_next = pending_reg & ~lowest_bit;
          addr_next    = addr_reg + STEP;
          if (last_xfer) begin
            state_next = DONE;
          end
        end
        // An abort still lets the current transfer strobe, but ends the sequence silently.
        if (abort) begin
          pending_next = '0;
          state_next   = IDLE;
        end
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        pending_next = '0;
        state_next   = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: expected transfers are queued when a
// sequence is issued and compared by a negedge monitor as the DUT performs them.
module tb_lmsm_sequencer;
  logic clk;
  logic rst;

  lmsm_sequencer_if #(.ADDR_WIDTH(16), .MASK_WIDTH(8)) bus ();

  lmsm_sequencer #(.ADDR_WIDTH(16), .MASK_WIDTH(8), .ADDR_STEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] addr;
    logic        we;
    logic        rf;
  } xfer_t;

  xfer_t sb_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    done_count   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every active transfer cycle is compared to the head of the scoreboard;
  // the entry is retired only when memory accepts it.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) done_count++;
      if (bus.mem_en) begin
        if (sb_q.size() == 0) begin
          check("xfer_unexpected", 32'd1, 32'd0);
        end else begin
          xfer_t e;
          e = sb_q[0];
          check("reg_idx", 32'(bus.reg_idx), 32'(e.idx));
          check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("mem_we", 32'(bus.mem_we), 32'(e.we));
          check("rf_we", 32'(bus.rf_we), 32'(e.rf & bus.mem_rdy));
          check("addr_sel", 32'(bus.addr_sel), 32'd1);
          check("busy_xfer", 32'(bus.busy), 32'd1);
          $display("[TB] xfer idx=%0d addr=%04h we=%0b rf_we=%0b rdy=%0b",
                   bus.reg_idx, bus.mem_addr, bus.mem_we, bus.rf_we, bus.mem_rdy);
          if (bus.mem_rdy) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_addr_sel"}, 32'(bus.addr_sel), 32'd0);
    check({tag, "_reg_idx"}, 32'(bus.reg_idx), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  // Queue the expected transfers for a mask (lowest bit first, address wraps), at most 'limit'.
  task automatic push_expected(input logic st, input logic [7:0] m, input logic [15:0] base,
                               input int limit, output int n);
    xfer_t e;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && n < limit) begin
        e.idx  = 3'(i);
        e.addr = base + 16'(n);
        e.we   = st;
        e.rf   = ~st;
        sb_q.push_back(e);
        n++;
      end
    end
  endtask

  // Issue one sequence. stall: cycles mem_rdy is held low at the start.
  // poke: pulse start with a different mask while busy. flush_at>0: abort in that XFER cycle.
  task automatic run_op(input string name, input logic st, input logic [7:0] m,
                        input logic [15:0] base, input int stall, input bit poke,
                        input int flush_at);
    int n;
    int c;
    int dc0;
    bit got;
    push_expected(st, m, base, (flush_at > 0) ? flush_at : 8, n);
    dc0 = done_count;
    bus.is_store  = st;
    bus.mask      = m;
    bus.base_addr = base;
    bus.start     = 1'b1;
    bus.mem_rdy   = (stall == 0);
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.mask      = 8'($urandom);
    bus.base_addr = 16'($urandom);
    got = 1'b0;
    for (c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (flush_at > 0 && c == flush_at + 1) break;
      @(posedge clk); #1;
      bus.start = poke && (c == 1);
      if (poke && c == 1) bus.mask = 8'hFF;
      if (c >= stall) bus.mem_rdy = 1'b1;
`ifdef LMSM_FLUSH_EN
      bus.flush = (flush_at > 0) && (c == flush_at - 1);
`endif
    end
    if (flush_at > 0) begin
      check({name, "_flush_busy"}, 32'(bus.busy), 32'd0);
      check({name, "_flush_no_done"}, 32'(got), 32'd0);
      @(negedge clk);
      check({name, "_flush_done_cnt"}, 32'(done_count - dc0), 32'd0);
    end else begin
      check({name, "_done_seen"}, 32'(got), 32'd1);
      check({name, "_done_latency"}, 32'(c), 32'(n + 1 + stall));
      check({name, "_busy_at_done"}, 32'(bus.busy), 32'd1);
      check({name, "_mem_en_at_done"}, 32'(bus.mem_en), 32'd0);
      @(negedge clk);
      check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({name, "_done_once"}, 32'(done_count - dc0), 32'd1);
    end
    check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    $display("[TB] op %s store=%0b mask=%02h base=%04h cycles=%0d", name, st, m, base, c);
    sb_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int dc0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_store  = 1'b0;
    bus.mask      = '0;
    bus.base_addr = '0;
    bus.mem_rdy   = 1'b1;
`ifdef LMSM_FLUSH_EN
    bus.flush     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("lm_a5", 1'b0, 8'hA5, 16'h0100, 0, 1'b0, 0);
    run_op("sm_00", 1'b1, 8'h00, 16'h0200, 0, 1'b0, 0);
    run_op("sm_03_stall", 1'b1, 8'h03, 16'h0040, 2, 1'b0, 0);
    run_op("lm_81_wrap", 1'b0, 8'h81, 16'hFFFF, 0, 1'b0, 0);

    // Reset during the second transfer of a full-mask load.
    push_expected(1'b0, 8'hFF, 16'h0010, 8, n);
    dc0 = done_count;
    bus.is_store  = 1'b0;
    bus.mask      = 8'hFF;
    bus.base_addr = 16'h0010;
    bus.start     = 1'b1;
    bus.mem_rdy   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_pre_mem_en", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_after");
    check("rst_no_done", 32'(done_count - dc0), 32'd0);
    @(posedge clk); #1;

    run_op("lm_06_poke", 1'b0, 8'h06, 16'h0020, 0, 1'b1, 0);

`ifdef LMSM_FLUSH_EN
    run_op("lm_0f_flush", 1'b0, 8'h0F, 16'h0300, 0, 1'b0, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
